mux_seg_display: RTL and testbench
==================================

// Module: mux_seg_display
// PURPOSE
//  Parametrised multiplexed 7-segment display controller. Captures a W-bit binary value on a load pulse,
//  shows it as hex (direct nibbles) or decimal (iterative double-dabble), and scans N_DIG common-anode digits.
//  Adds leading-zero blanking, per-digit DP mask, decimal overflow indication and a glitch-free display buffer.
//  Sits between datapath results (register bank / ALU readout) and the board SEG/AN/DP pins.
// PARAMETERS
//  W           32     width of input value (>=4, multiple of 4)
//  N_DIG       8      number of physical digits (1..16)
//  REFRESH_DIV 100000 CLK cycles each digit is held active (>=2)
//  localparam BCD_D = digits needed for 2^W-1 in decimal (10 for W=32); HEX_D = W/4
// PORTS
//  CLK      in   1      system clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  value    in   W      binary value to display
//  load     in   1      one-cycle capture strobe for value/mode
//  mode     in   1      0 = hex, 1 = unsigned decimal; sampled with load
//  blank_lz in   1      1 = blank leading zero digits (digit 0 always shown); sampled live
//  dp_mask  in   N_DIG  1 = light DP on that digit; sampled live
//  busy     out  1      decimal conversion in progress
//  SEG      out  7      {g,f,e,d,c,b,a}, active low
//  AN       out  N_DIG  digit enables, active low, one-hot-zero
//  DP       out  1      decimal point, active low
// BEHAVIOUR
//  Reset: SEG=7'h7F, AN=all 1, DP=1, busy=0, display buffer=0, digit index=0, prescaler=0, mode reg=0.
//  Load accepted only when busy=0; load while busy ignored (no queueing).
//  Hex: load at edge k -> buffer holds the nibbles of value after edge k; busy never asserts.
//  Decimal: load at edge k -> busy=1 after k; one shift/add-3 iteration per edge k+1..k+W;
//   at edge k+W the BCD result is written to the buffer and busy=0 (busy high exactly W cycles).
//  Buffer updates only at completion; the old value is displayed throughout conversion.
//  Digits of value above N_DIG (hex, HEX_D>N_DIG) are dropped silently.
//  Decimal overflow: any nonzero BCD digit at index >= N_DIG -> every digit shows '-' (7'h3F), blanking off.
//  Blanking: when blank_lz=1, digits above the most significant nonzero digit show 7'h7F; value 0 shows '0'.
//  Scan: prescaler counts 0..REFRESH_DIV-1; on wrap, digit index advances, N_DIG-1 wraps to 0.
//   AN[i]=0 only for the current index; SEG and DP are registered together with AN (same cycle, no ghosting).
//  DP = ~dp_mask[index]; DP is independent of blanking and overflow.
//  Glyphs: 0-9 and A-F standard; 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Reset mid-conversion aborts it: busy=0, buffer=0; the next load starts cleanly.
//  Simultaneous load and conversion completion: completion wins, load ignored (busy was 1 at that edge).
// STRUCTURE
//  seg_defs.vh include: glyph localparams (GLYPH_0..F, GLYPH_DASH, GLYPH_BLANK), MODE_HEX/MODE_DEC.
//  Sub-module bcd_seq_conv #(W,BCD_D): start/value in, busy/done/bcd out, shift-add-3 FSM IDLE->SHIFT(xW)->IDLE.
//  Top: capture regs, display buffer, blank/overflow logic, prescaler + digit counter, glyph ROM.
// TESTING (bench: W=32, N_DIG=8, REFRESH_DIV=4)
//  1 Scan: after reset, no load -> AN steps FE,FD,FB..7F each held 4 cycles, wraps to FE; SEG=40 on digit 0, 7F elsewhere when blank_lz=1.
//  2 Hex: load 32'h0000_00A5 mode=0 blank_lz=1 -> next cycle digit0 SEG=12, digit1 SEG=08, digits2-7 SEG=7F; busy stays 0.
//  3 Dec: load 12345 mode=1 -> busy=1 for exactly 32 cycles; then digits0..4 = 12,19,30,24,79; old value shown meanwhile.
//  4 Overflow: load 32'hFFFF_FFFF mode=1 -> after completion all 8 digits SEG=3F; load 99999999 -> 8 digits SEG=10.
//  5 Busy/priority: load 7 mode=1, reload 9 at busy cycle 10 -> ignored, final display 7; load on completion edge ignored.
//  6 Reset: assert rst at busy cycle 15 -> busy=0, SEG=7F, AN=FF immediately (async); then load 42 -> shows 42 after 32 cycles.

Source files
------------

// File: rtl/mux_seg_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// glyph codes (active low {g,f,e,d,c,b,a}), mode encodings, converter states and helpers.
package mux_seg_display_pkg;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_t;

  // 2^w-1 never lands on a power of ten, so its digit count is floor(w*log10(2))+1.
  function automatic int bcd_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mux_seg_display_bcd.sv
// Sequential binary-to-BCD converter (shift/add-3), one bit per clock, W clocks per conversion.
// o_done and o_bcd are combinational so the caller can capture the result on the final shift edge.
module bcd_seq_conv
  import mux_seg_display_pkg::*;
#(
  parameter int W     = 32,
  parameter int BCD_D = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [W-1:0]       i_value,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_D*4-1:0] o_bcd
);

  localparam int CNT_W = $clog2(W);

  conv_state_t          r_state;
  conv_state_t          w_state_nxt;
  logic [W-1:0]         r_bin;
  logic [BCD_D*4-1:0]   r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic [BCD_D*4-1:0]   w_adj;
  logic [BCD_D*4-1:0]   w_bcd_shift;
  logic                 w_last;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < BCD_D; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
    w_bcd_shift = {w_adj[BCD_D*4-2:0], r_bin[W-1]};
  end

  assign w_last = (r_cnt == CNT_W'(W - 1));

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      CONV_IDLE: begin
        if (i_start) w_state_nxt = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        if (w_last) begin
          w_state_nxt = CONV_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CONV_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CONV_IDLE) begin
        if (i_start) begin
          r_bin <= i_value;
          r_bcd <= '0;
          r_cnt <= '0;
        end
      end else begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_shift;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy = (r_state == CONV_SHIFT);
  assign o_bcd  = w_bcd_shift;

endmodule

// File: rtl/mux_seg_display.sv
// Multiplexed common-anode 7-segment controller: captures a value in hex or decimal,
// holds it in a display buffer, and scans the digits with blanking, DP mask and overflow dashes.
module mux_seg_display
  import mux_seg_display_pkg::*;
#(
  parameter int W           = 32,
  parameter int N_DIG       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [W-1:0]     value,
  input  logic             load,
  input  logic             mode,
  input  logic             blank_lz,
  input  logic [N_DIG-1:0] dp_mask,
  output logic             busy,
  output logic [6:0]       SEG,
  output logic [N_DIG-1:0] AN,
  output logic             DP
);

  localparam int BCD_D = bcd_digits(W);
  localparam int BUF_W = N_DIG * 4;
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic               r_mode;
  logic [BUF_W-1:0]   r_buf;
  logic               r_ovf;
  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic [6:0]         r_seg;
  logic [N_DIG-1:0]   r_an;
  logic               r_dp;

  logic               w_busy;
  logic               w_done;
  logic [BCD_D*4-1:0] w_bcd;
  logic               w_load_ok;
  logic               w_start;
  logic               w_dec_ovf;
  logic [IDX_W-1:0]   w_msd;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg_nxt;

  assign w_load_ok = load & ~w_busy;
  assign w_start   = w_load_ok & (mode == MODE_DEC);

  bcd_seq_conv #(
    .W     (W),
    .BCD_D (BCD_D)
  ) u_conv (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_start (w_start),
    .i_value (value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Any decimal digit that has no physical position to land on turns the display into dashes.
  always_comb begin
    w_dec_ovf = 1'b0;
    for (int d = 0; d < BCD_D; d++) begin
      if (d >= N_DIG && w_bcd[d*4 +: 4] != 4'd0) w_dec_ovf = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_HEX;
      r_buf  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load_ok) r_mode <= mode;
      if (w_done) begin
        r_buf <= BUF_W'(w_bcd);
        r_ovf <= w_dec_ovf & (r_mode == MODE_DEC);
      end else if (w_load_ok && mode == MODE_HEX) begin
        r_buf <= BUF_W'(value);
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_msd = '0;
    for (int d = 0; d < N_DIG; d++) begin
      if (r_buf[d*4 +: 4] != 4'd0) w_msd = IDX_W'(d);
    end
    w_nib = r_buf[int'(r_idx)*4 +: 4];
    if (r_ovf)                          w_seg_nxt = GLYPH_DASH;
    else if (blank_lz && r_idx > w_msd) w_seg_nxt = GLYPH_BLANK;
    else                                w_seg_nxt = glyph(w_nib);
  end

  // AN, SEG and DP all come from the same index in the same register stage, so no ghosting.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= GLYPH_BLANK;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else begin
      if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_W'(N_DIG - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_seg <= w_seg_nxt;
      r_an  <= ~(N_DIG'(1) << r_idx);
      r_dp  <= ~dp_mask[r_idx];
    end
  end

  assign busy = w_busy;
  assign SEG  = r_seg;
  assign AN   = r_an;
  assign DP   = r_dp;

endmodule

// File: tb/tb_mux_seg_display.sv
// Directed self-checking bench for mux_seg_display (W=32, N_DIG=8, REFRESH_DIV=4):
// scan order, hex/decimal display, overflow dashes, load priority and async reset abort.
module tb_mux_seg_display;

  logic        CLK = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        mode;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic        busy;
  logic [6:0]  SEG;
  logic [7:0]  AN;
  logic        DP;

  int checks = 0;
  int errors = 0;
  int n;
  bit found;
  logic [6:0] oldTab [8];

  mux_seg_display #(
    .W           (32),
    .N_DIG       (8),
    .REFRESH_DIV (4)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .SEG      (SEG),
    .AN       (AN),
    .DP       (DP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle load pulse captured at the next rising edge; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [31:0] v, input logic m);
    @(negedge CLK);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
  endtask

  task automatic waitDigit(input int idx, output bit ok);
    logic [7:0] target;
    target = ~(8'h01 << idx);
    ok = 1'b0;
    @(posedge CLK);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (AN === target) ok = 1'b1;
    end
    if (!ok) checkOutput("digit_timeout", {24'h0, AN}, {24'h0, target});
  endtask

  task automatic checkDigit(input string tag, input int idx, input logic [6:0] expSeg);
    bit ok;
    waitDigit(idx, ok);
    if (ok) checkOutput(tag, {25'h0, SEG}, {25'h0, expSeg});
  endtask

  task automatic checkCurrent(input string tag);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) if (AN[i] === 1'b0) idx = i;
    checkOutput(tag, {25'h0, SEG}, {25'h0, oldTab[idx]});
  endtask

  task automatic measureBusy(output int cnt);
    cnt = 0;
    @(negedge CLK);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge CLK);
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    mode     = 1'b0;
    blank_lz = 1'b1;
    dp_mask  = 8'h00;
    repeat (3) @(negedge CLK);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_seg",  {25'h0, SEG},  32'h7F);
    checkOutput("reset_an",   {24'h0, AN},   32'hFF);
    checkOutput("reset_dp",   {31'h0, DP},   32'h1);
    rst = 1'b0;

    $display("[TB] scan order after reset");
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge CLK);
        checkOutput("scan_an", {24'h0, AN}, {24'h0, ~(8'h01 << (s % 8))});
        if (c == 0) begin
          checkOutput("scan_seg", {25'h0, SEG}, (s % 8 == 0) ? 32'h40 : 32'h7F);
          checkOutput("scan_dp",  {31'h0, DP},  32'h1);
        end
      end
    end

    $display("[TB] hex load 0xA5");
    applyStimulus(32'h0000_00A5, 1'b0);
    checkOutput("hex_busy", {31'h0, busy}, 32'h0);
    checkDigit("hex_d0", 0, 7'h12);
    checkDigit("hex_d1", 1, 7'h08);
    checkDigit("hex_d2", 2, 7'h7F);
    checkDigit("hex_d7", 7, 7'h7F);
    checkOutput("hex_busy_after", {31'h0, busy}, 32'h0);

    dp_mask = 8'h02;
    waitDigit(1, found);
    if (found) checkOutput("dp_on_d1", {31'h0, DP}, 32'h0);
    waitDigit(2, found);
    if (found) checkOutput("dp_off_d2", {31'h0, DP}, 32'h1);
    dp_mask = 8'h00;

    $display("[TB] decimal load 12345");
    oldTab = '{7'h12, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    applyStimulus(32'd12345, 1'b1);
    n = 0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5 || n == 20) checkCurrent("dec_old_value");
      @(negedge CLK);
    end
    checkOutput("dec_busy_len", n, 32);
    checkDigit("dec_d0", 0, 7'h12);
    checkDigit("dec_d1", 1, 7'h19);
    checkDigit("dec_d2", 2, 7'h30);
    checkDigit("dec_d3", 3, 7'h24);
    checkDigit("dec_d4", 4, 7'h79);
    checkDigit("dec_d5", 5, 7'h7F);

    $display("[TB] decimal overflow and largest fitting value");
    applyStimulus(32'hFFFF_FFFF, 1'b1);
    measureBusy(n);
    checkOutput("ovf_busy_len", n, 32);
    checkDigit("ovf_d0", 0, 7'h3F);
    checkDigit("ovf_d3", 3, 7'h3F);
    checkDigit("ovf_d7", 7, 7'h3F);
    applyStimulus(32'd99999999, 1'b1);
    measureBusy(n);
    checkDigit("nines_d0", 0, 7'h10);
    checkDigit("nines_d7", 7, 7'h10);

    $display("[TB] load while busy and on completion edge");
    applyStimulus(32'd7, 1'b1);
    repeat (9) @(negedge CLK);
    value = 32'd9;
    mode  = 1'b1;
    load  = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
    repeat (23) @(negedge CLK);
    checkOutput("prio_busy_before_done", {31'h0, busy}, 32'h1);
    value = 32'd5;
    mode  = 1'b1;
    load  = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
    checkOutput("prio_busy_after_done", {31'h0, busy}, 32'h0);
    checkDigit("prio_d0", 0, 7'h78);
    checkDigit("prio_d1", 1, 7'h7F);

    $display("[TB] reset during conversion");
    applyStimulus(32'd7777, 1'b1);
    repeat (14) @(negedge CLK);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_seg",  {25'h0, SEG},  32'h7F);
    checkOutput("abort_an",   {24'h0, AN},   32'hFF);
    @(negedge CLK);
    rst = 1'b0;
    applyStimulus(32'd42, 1'b1);
    measureBusy(n);
    checkOutput("post_reset_busy_len", n, 32);
    checkDigit("post_reset_d0", 0, 7'h24);
    checkDigit("post_reset_d1", 1, 7'h19);
    checkDigit("post_reset_d2", 2, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
